// File: rtl/regfile_arbiter_if.sv
// Bundle between two requesters, the arbiter and a shared register file.
// The arbiter takes the slave modport; the clients and the register file take the master modport.
interface regfile_arbiter_if #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 2
);
  logic         req0;
  logic         we0;
  logic [W-1:0] addr0;
  logic [B-1:0] wdata0;
  logic         req1;
  logic         we1;
  logic [W-1:0] addr1;
  logic [B-1:0] wdata1;
  logic         ack0;
  logic         ack1;
  logic [B-1:0] rd_data;
  logic         busy;
  logic         rf_wr_en;
  logic [W-1:0] rf_w_addr;
  logic [W-1:0] rf_r_addr;
  logic [B-1:0] rf_w_data;
  logic [B-1:0] rf_r_data;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, rf_r_data,
    output ack0, ack1, rd_data, busy, rf_wr_en, rf_w_addr, rf_r_addr, rf_w_data
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, rf_r_data,
    input  ack0, ack1, rd_data, busy, rf_wr_en, rf_w_addr, rf_r_addr, rf_w_data
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-client round-robin arbiter that serialises single read/write transactions
// onto one register file: IDLE -> ACCESS -> ACK, one transaction per three cycles.
module regfile_arbiter #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 2
) (
  input logic             clk,
  input logic             reset,
  regfile_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StAck    = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         win_q, win_d;
  logic         we_q, we_d;
  logic [W-1:0] addr_q, addr_d;
  logic [B-1:0] wdata_q, wdata_d;
  logic [B-1:0] rd_data_q, rd_data_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // Under contention the requester that was not served last wins.
          win_d   = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
          we_d    = win_d ? bus.we1    : bus.we0;
          addr_d  = win_d ? bus.addr1  : bus.addr0;
          wdata_d = win_d ? bus.wdata1 : bus.wdata0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Captures pre-write contents: the write lands on this same edge.
        rd_data_d = bus.rf_r_data;
        state_d   = StAck;
      end
      StAck: begin
        last_grant_d = win_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Gated by reset so an ACCESS cut short by reset never commits its write.
  assign bus.rf_wr_en  = (state_q == StAccess) && we_q && !reset;
  assign bus.rf_w_addr = addr_q;
  assign bus.rf_r_addr = addr_q;
  assign bus.rf_w_data = wdata_q;
  assign bus.ack0      = (state_q == StAck) && !win_q;
  assign bus.ack1      = (state_q == StAck) && win_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 4-entry register file attached.
module tb_regfile_arbiter;
  localparam int unsigned B = 8;
  localparam int unsigned W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.B(B), .W(W)) bus ();
  regfile_arbiter #(.B(B), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [B-1:0] mem [4] = '{default: '0};
  always @(posedge clk) if (bus.rf_wr_en) mem[bus.rf_w_addr] <= bus.rf_w_data;
  assign bus.rf_r_data = mem[bus.rf_r_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int wr_run  = 0;
  int wr_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Every write-enable pulse must be exactly one cycle; acks are mutually exclusive.
  always @(negedge clk) begin
    if (bus.rf_wr_en) begin
      wr_run++;
      if (wr_run == 1) wr_total++;
      check_eq("wr_en_single_cycle", 32'(wr_run), 32'd1);
    end else begin
      wr_run = 0;
    end
    if (bus.ack0 || bus.ack1) check_eq("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit r, input bit we, input logic [W-1:0] a,
                       input logic [B-1:0] wd);
    if (id) begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
    end else begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
    end
  endtask

  task automatic txn_single(input bit id, input bit we, input logic [W-1:0] a,
                            input logic [B-1:0] wd, input logic [B-1:0] exp_rd,
                            input string tag);
    drive(id, 1'b1, we, a, wd);
    check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    step();
    check_eq({tag, "_acc_busy"}, 32'(bus.busy), 32'd1);
    check_eq({tag, "_acc_wr_en"}, 32'(bus.rf_wr_en), 32'(we));
    check_eq({tag, "_acc_waddr"}, 32'(bus.rf_w_addr), 32'(a));
    check_eq({tag, "_acc_raddr"}, 32'(bus.rf_r_addr), 32'(a));
    if (we) check_eq({tag, "_acc_wdata"}, 32'(bus.rf_w_data), 32'(wd));
    check_eq({tag, "_acc_noack"}, 32'(bus.ack0 | bus.ack1), 32'd0);
    step();
    check_eq({tag, "_ack_mine"}, 32'(id ? bus.ack1 : bus.ack0), 32'd1);
    check_eq({tag, "_ack_other"}, 32'(id ? bus.ack0 : bus.ack1), 32'd0);
    check_eq({tag, "_rd_data"}, 32'(bus.rd_data), 32'(exp_rd));
    check_eq({tag, "_ack_wr_en"}, 32'(bus.rf_wr_en), 32'd0);
    drive(id, 1'b0, we, a, wd);
    step();
    check_eq({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_post_noack"}, 32'(bus.ack0 | bus.ack1), 32'd0);
  endtask

  // Both requests already asserted; expects grants alternating from 'first'.
  task automatic contest(input int n, input bit first, input logic [B-1:0] exp_rd0,
                         input logic [B-1:0] exp_rd1, input string tag);
    for (int k = 0; k < n; k++) begin
      bit w;
      w = first ^ k[0];
      check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      step();
      check_eq({tag, "_acc_busy"}, 32'(bus.busy), 32'd1);
      check_eq({tag, "_acc_addr"}, 32'(bus.rf_w_addr), 32'(w ? bus.addr1 : bus.addr0));
      check_eq({tag, "_acc_wr_en"}, 32'(bus.rf_wr_en), 32'(w ? bus.we1 : bus.we0));
      step();
      check_eq({tag, "_ack0"}, 32'(bus.ack0), 32'(!w));
      check_eq({tag, "_ack1"}, 32'(bus.ack1), 32'(w));
      check_eq({tag, "_rd_data"}, 32'(bus.rd_data), 32'(w ? exp_rd1 : exp_rd0));
      check_eq({tag, "_ack_busy"}, 32'(bus.busy), 32'd1);
      if (k == n - 1) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    step();
    step();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
    check_eq("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check_eq("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    check_eq("rst_waddr", 32'(bus.rf_w_addr), 32'd0);
    check_eq("rst_raddr", 32'(bus.rf_r_addr), 32'd0);
    check_eq("rst_wdata", 32'(bus.rf_w_data), 32'd0);
    reset = 1'b0;
    check_eq("post_rst_wr_en", 32'(bus.rf_wr_en), 32'd0);

    txn_single(1'b0, 1'b1, 2'd2, 8'h6E, 8'h00, "t1_wr");
    txn_single(1'b1, 1'b0, 2'd2, 8'h00, 8'h6E, "t2_rd");

    // Contested writes straight out of reset: requester 0 first.
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h64);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 8'h65);
    step();
    reset = 1'b0;
    contest(2, 1'b0, 8'h00, 8'h00, "t3");

    drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
    contest(8, 1'b0, 8'h64, 8'h65, "t4");

    txn_single(1'b0, 1'b1, 2'd3, 8'h11, 8'h00, "t5a");
    txn_single(1'b1, 1'b1, 2'd3, 8'h78, 8'h11, "t5b");
    txn_single(1'b0, 1'b0, 2'd3, 8'h00, 8'h78, "t5c");

    // Abort a write in ACCESS; last grant was 0, so only reset makes 0 win next.
    drive(1'b0, 1'b1, 1'b1, 2'd1, 8'hFF);
    step();
    check_eq("t6_acc_wr_en", 32'(bus.rf_wr_en), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    reset = 1'b0;
    check_eq("t6_no_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    step();
    check_eq("t6_no_ack_late", 32'({bus.ack0, bus.ack1}), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    contest(2, 1'b0, 8'h65, 8'h64, "t6");

    check_eq("write_pulse_total", 32'(wr_total), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one shared reg_file instance.
- Sits between two client blocks and the register file's write/read ports.
- Each client issues a single read or write transaction with a req/ack handshake.
- The arbiter serialises access, drives the register file ports from registered state, and returns read data with a one-cycle ack.

Parameters:
- B, 8, data width in bits; must match the attached register file.
- W, 2, address width in bits; register file depth is 2**W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 transaction request; held high until ack0.
- we0  input  1  requester 0 operation: 1 = write, 0 = read; stable while req0 is high.
- addr0  input  W  requester 0 address; stable while req0 is high.
- wdata0  input  B  requester 0 write data; stable while req0 is high.
- req1, we1, addr1, wdata1  input  1/1/W/B  requester 1 equivalents, same rules.
- ack0  output  1  one-cycle completion strobe to requester 0.
- ack1  output  1  one-cycle completion strobe to requester 1.
- rd_data  output  B  data returned for the acked transaction; valid while ack0 or ack1 is high.
- busy  output  1  high in any state other than IDLE.
- rf_wr_en  output  1  register file write enable.
- rf_w_addr  output  W  register file write address.
- rf_r_addr  output  W  register file read address.
- rf_w_data  output  B  register file write data.
- rf_r_data  input  B  register file combinational read data.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on the port named reset.
- Reset values:
  - FSM = IDLE; ack0 = ack1 = 0; busy = 0; rd_data = 0.
  - rf_wr_en = 0; rf_w_addr = rf_r_addr = 0; rf_w_data = 0.
  - last_grant = 1, so requester 0 wins the first contested arbitration.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Sample req0 and req1 every cycle.
  - Neither high: stay in IDLE.
  - Exactly one high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - On a win, at the clock edge: latch the winner's we, addr and wdata, plus the winner id, into command registers; go to ACCESS.
- ACCESS (exactly one cycle):
  - rf_w_addr = rf_r_addr = latched addr.
  - rf_w_data = latched wdata.
  - rf_wr_en = latched we. It is low in every other state.
  - At the edge ending ACCESS: rd_data <= rf_r_data; write commits if we = 1; go to ACK.
- Write ops: rd_data returns the pre-write contents of the address. The read is combinational and the write lands at the same edge.
- ACK (exactly one cycle):
  - ack of the latched winner = 1; the other ack = 0.
  - last_grant <= winner id.
  - Next state IDLE.
- Handshake rules:
  - The requester deasserts req at the edge ending its ack cycle.
  - A req still high in the following IDLE cycle is treated as a new transaction.
- Latency:
  - req high in IDLE cycle N gives ack in cycle N+2.
  - Back-to-back throughput is one transaction per 3 cycles.
  - Under continuous contention, grants alternate 0,1,0,1.
- The losing requester's req stays pending, with no ack, until it is granted. The bench must see no starvation: worst-case wait is one transaction.
- rf_wr_en must never be high for more than one cycle per transaction.
- rf_wr_en is never high outside ACCESS, including in the cycle after reset.
- Reset mid-operation:
  - rf_wr_en is forced to 0 combinationally while reset is high, so an aborted ACCESS never commits a write.
  - No ack is issued for an aborted transaction.
  - FSM returns to IDLE; last_grant returns to 1.
- Address wrap: addr is W bits; no out-of-range access is possible.
- A req asserting in ACCESS or ACK is ignored until the next IDLE cycle.

Test Plan:
- Reset, then req0 write addr=2 wdata=8'h6E held until ack → rf_wr_en high for exactly one cycle with rf_w_addr=2; ack0 in the second cycle after req sampled; ack1 never high.
- Following req1 read addr=2 → ack1 with rd_data=8'h6E; rf_wr_en stays 0 throughout.
- req0 and req1 both high from reset, writes to addr 0 (8'h64) and addr 1 (8'h65) → ack0 first, then ack1 three cycles later; reads of addr 0 and 1 then return 8'h64 and 8'h65.
- Both requesters continuously re-requesting for 8 transactions → grant order strictly 0,1,0,1,...; busy high except single IDLE cycles.
- Write 8'h78 to addr 3 over prior contents 8'h11 → rd_data on the ack cycle = 8'h11; a subsequent read of addr 3 = 8'h78.
- Reset asserted during ACCESS of a write of 8'hFF to addr 1 → no ack; rf_wr_en low that cycle; addr 1 keeps its old value; the next contested grant goes to requester 0.
